mult_scheduler: RTL and testbench

Sequencing and sharing controller for the iterative 32-bit Booth multiplier. It arbitrates round-robin between NUM_REQ requesters, latches the winner's operands, and holds them stable for the full iteration. It pulses the multiplier's restart input, waits for the result-ready flag (bounded by a watchdog), and returns the product and exception flag tagged with the requester id. It sits between the processor's execute stage and the arm-kinematics unit on one side, and the single multiplier instance on the other.

---
 rtl/mult_sched_pkg.sv | 27 ++
 rtl/mult_scheduler_rr_arbiter.sv | 48 ++++
 rtl/mult_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mult_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// ============================================================================
//  Module      : mult_sched_pkg
//  Description : Shared types and constants for the Booth multiplier scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_sched_pkg;

    localparam int c_OP_W         = 32;
    localparam int c_MAX_WAIT_DEF = 40;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Width of a requester id; never below one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_scheduler_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter, one-hot grant plus index.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_hi_mask;
    logic [NUM_REQ-1:0] w_hi_req;
    logic [NUM_REQ-1:0] w_sel;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    always_comb begin
        w_hi_mask = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_hi_mask[j] = (j >= int'(i_ptr));
        end
        w_hi_req = i_req & w_hi_mask;
        w_sel    = (|w_hi_req) ? w_hi_req : i_req;

        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_sel[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = ID_W'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_scheduler.sv
// ============================================================================
//  Module      : mult_scheduler
//  Description : Round-robin sharing controller for one iterative 32-bit
//                Booth multiplier. Optional MULT_SCHED_BYPASS_EN short-cuts
//                trivial operands (0 or 1) without running the multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_WAIT = c_MAX_WAIT_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*c_OP_W-1:0]     req_opA,
    input  logic [NUM_REQ*c_OP_W-1:0]     req_opB,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(NUM_REQ)-1:0]  rsp_id,
    output logic [c_OP_W-1:0]             rsp_result,
    output logic                          rsp_exception,
    output logic [c_OP_W-1:0]             mult_opA,
    output logic [c_OP_W-1:0]             mult_opB,
    output logic                          mult_res,
    input  logic [c_OP_W-1:0]             mult_result,
    input  logic                          mult_exception,
    input  logic                          mult_rdy,
    output logic                          busy
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_wait;
    logic [c_OP_W-1:0]   r_opA;
    logic [c_OP_W-1:0]   r_opB;
    logic [ID_W-1:0]     r_id;
    logic [c_OP_W-1:0]   r_result;
    logic                r_exc;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic [c_OP_W-1:0]   w_selA;
    logic [c_OP_W-1:0]   w_selB;
    logic                w_triv;
    logic [c_OP_W-1:0]   w_triv_res;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_selA = '0;
        w_selB = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_selA = req_opA[j*c_OP_W +: c_OP_W];
                w_selB = req_opB[j*c_OP_W +: c_OP_W];
            end
        end
    end

`ifdef MULT_SCHED_BYPASS_EN
    always_comb begin
        w_triv     = 1'b0;
        w_triv_res = '0;
        if (w_selA == '0 || w_selB == '0) begin
            w_triv = 1'b1;
        end else if (w_selA == c_OP_W'(1)) begin
            w_triv     = 1'b1;
            w_triv_res = w_selB;
        end else if (w_selB == c_OP_W'(1)) begin
            w_triv     = 1'b1;
            w_triv_res = w_selA;
        end
    end
`else
    assign w_triv     = 1'b0;
    assign w_triv_res = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_wait   <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_id     <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_rr_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
                        r_opA    <= w_selA;
                        r_opB    <= w_selB;
                        r_id     <= w_idx;
                        if (w_triv) begin
                            r_result <= w_triv_res;
                            r_exc    <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_wait  <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    // Zero count marks the first RUN cycle, where mult_rdy is stale.
                    if (r_wait != '0 && mult_rdy) begin
                        r_result <= mult_result;
                        r_exc    <= mult_exception;
                        r_state  <= S_DONE;
                    end else if (r_wait == CNT_W'(MAX_WAIT - 1)) begin
                        r_result <= '0;
                        r_exc    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE && !reset) ? w_grant : '0;
    assign rsp_valid     = (r_state == S_DONE);
    assign rsp_id        = r_id;
    assign rsp_result    = r_result;
    assign rsp_exception = r_exc;
    assign mult_opA      = r_opA;
    assign mult_opB      = r_opB;
    assign mult_res      = reset | (r_state == S_START);
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_scheduler.sv
// ============================================================================
//  Module      : tb_mult_scheduler
//  Description : Randomised self-checking bench with a 32-cycle multiplier stub.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_scheduler;

    localparam int NR = 3;
    localparam int MW = 40;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*32-1:0]  req_opA;
    logic [NR*32-1:0]  req_opB;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_exception;
    logic [31:0]       mult_opA;
    logic [31:0]       mult_opB;
    logic              mult_res;
    logic [31:0]       mult_result;
    logic              mult_exception;
    logic              mult_rdy;
    logic              busy;

    always #5 clock = ~clock;

    mult_scheduler #(
        .NUM_REQ (NR),
        .MAX_WAIT(MW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_opA       (req_opA),
        .req_opB       (req_opB),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_exception (rsp_exception),
        .mult_opA      (mult_opA),
        .mult_opB      (mult_opB),
        .mult_res      (mult_res),
        .mult_result   (mult_result),
        .mult_exception(mult_exception),
        .mult_rdy      (mult_rdy),
        .busy          (busy)
    );

    // Multiplier stub: ready flag lags the iteration counter, so it is stale
    // (still high) in the first cycle after a restart.
    logic [5:0]  s_cnt;
    logic        s_rdy_q;
    logic        s_hang;
    logic [63:0] s_prod;

    always @(posedge clock) begin
        if (mult_res)          s_cnt <= 6'd1;
        else if (s_cnt != 6'd32) s_cnt <= s_cnt + 6'd1;
        s_rdy_q <= (s_cnt == 6'd32);
    end
    assign s_prod         = {32'b0, mult_opA} * {32'b0, mult_opB};
    assign mult_result    = s_prod[31:0];
    assign mult_exception = |s_prod[63:32];
    assign mult_rdy       = s_rdy_q && !s_hang;

    int          n_total = 0;
    int          n_bad   = 0;
    int          m_ptr   = 0;
    logic [31:0] opa [NR];
    logic [31:0] opb [NR];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_pick(input logic [NR-1:0] m, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int i = (ptr + k) % NR;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        opa[i] = a;
        opb[i] = b;
        req_opA[i*32 +: 32] = a;
        req_opB[i*32 +: 32] = b;
    endtask

    // One full transaction: grant, response, optional backpressure, handshake.
    task automatic serve(input logic [NR-1:0] mask, input int rdy_delay);
        int          win;
        int          lat;
        int          pulses;
        int          elat;
        bit          got;
        logic [63:0] p;
        logic [31:0] er;
        logic        ee;

        tick();
        req_valid = mask;
        win = model_pick(mask, m_ptr);
        got = 0;
        for (int c = 0; c < 5 && !got; c++) begin
            @(negedge clock);
            if (req_ready != '0) got = 1;
            else tick();
        end
        if (!got) begin
            check_eq("grant_timeout", 64'd0, 64'd1);
            req_valid = '0;
            return;
        end
        check_eq("grant", req_ready, 64'd1 << win);
        m_ptr = (win + 1) % NR;

        p    = {32'b0, opa[win]} * {32'b0, opb[win]};
        er   = p[31:0];
        ee   = |p[63:32];
        elat = 35;
        if (s_hang) begin
            er   = 32'd0;
            ee   = 1'b1;
            elat = MW + 2;
        end
`ifdef MULT_SCHED_BYPASS_EN
        if (opa[win] == 0 || opb[win] == 0) begin
            er = 32'd0; ee = 1'b0; elat = 1;
        end else if (opa[win] == 1) begin
            er = opb[win]; ee = 1'b0; elat = 1;
        end else if (opb[win] == 1) begin
            er = opa[win]; ee = 1'b0; elat = 1;
        end
`endif

        tick();
        req_valid[win] = 1'b0;
        lat    = 0;
        pulses = 0;
        got    = 0;
        while (!got && lat < MW + 20) begin
            @(negedge clock);
            lat++;
            if (mult_res) pulses++;
            if (rsp_valid) got = 1;
            else tick();
        end
        if (!got) begin
            check_eq("rsp_timeout", 64'd0, 64'd1);
            req_valid = '0;
            return;
        end
        check_eq("latency", lat, elat);
        check_eq("rsp_id", rsp_id, win);
        check_eq("rsp_result", rsp_result, er);
        check_eq("rsp_exc", rsp_exception, ee);
        check_eq("res_pulses", pulses, (elat == 1) ? 0 : 1);
        check_eq("mult_opA", mult_opA, opa[win]);

        for (int d = 0; d < rdy_delay; d++) begin
            tick();
            @(negedge clock);
            check_eq("hold_valid", rsp_valid, 1);
            check_eq("hold_result", {rsp_id, rsp_exception, rsp_result}, {win[IW-1:0], ee, er});
            check_eq("hold_ready0", req_ready, 0);
        end

        tick();
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("bubble", req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        req_valid = '0;
        @(negedge clock);
        check_eq("after_valid", rsp_valid, 0);
        check_eq("after_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NR-1:0] mask;
        int            seen;

        reset     = 1'b1;
        req_valid = '1;
        req_opA   = '0;
        req_opB   = '0;
        rsp_ready = 1'b0;
        s_hang    = 1'b0;
        for (int i = 0; i < NR; i++) set_ops(i, 32'd0, 32'd0);
        repeat (3) tick();
        @(negedge clock);
        check_eq("rst_mult_res", mult_res, 1);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_outputs", {rsp_valid, busy, rsp_id, rsp_exception, rsp_result},
                 {1'b0, 1'b0, 2'd0, 1'b0, 32'd0});
        check_eq("rst_ops", {mult_opA, mult_opB}, 64'd0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        m_ptr     = 0;

        set_ops(0, 32'd7, 32'd6);
        serve(3'b001, 0);

        set_ops(0, 32'h4000_0000, 32'd4);
        serve(3'b001, 0);

        s_hang = 1'b1;
        set_ops(2, 32'd123, 32'd456);
        serve(3'b100, 0);
        s_hang = 1'b0;
        set_ops(2, 32'd1000, 32'd1000);
        serve(3'b100, 1);

        set_ops(1, 32'd77, 32'd3);
        set_ops(2, 32'd9, 32'd9);
        serve(3'b110, 10);

        set_ops(1, 32'd1, 32'hFFFF_FFFB);
        serve(3'b010, 0);

        // Abandon an operation mid-RUN.
        tick();
        set_ops(0, 32'd5, 32'd9);
        req_valid = 3'b001;
        @(negedge clock);
        check_eq("rst_run_grant", req_ready, 3'b001);
        tick();
        req_valid = '0;
        repeat (10) tick();
        reset = 1'b1;
        @(negedge clock);
        check_eq("mid_rst_mult_res", mult_res, 1);
        tick();
        @(negedge clock);
        check_eq("mid_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        m_ptr = 0;
        seen  = 0;
        for (int c = 0; c < MW + 5; c++) begin
            @(negedge clock);
            if (rsp_valid) seen++;
            tick();
        end
        check_eq("mid_rst_no_rsp", seen, 0);

        set_ops(0, 32'd3, 32'd5);
        set_ops(1, 32'd11, 32'd13);
        serve(3'b011, 0);
        serve(3'b011, 0);
        serve(3'b011, 2);

        for (int r = 0; r < 40; r++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 3))
                    0: set_ops(i, $urandom_range(0, 1000), $urandom_range(0, 1000));
                    1: set_ops(i, $urandom, $urandom);
                    2: set_ops(i, $urandom_range(0, 1), $urandom);
                    default: set_ops(i, $urandom | 32'h8000_0000, $urandom_range(2, 255));
                endcase
            end
            serve(mask, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
